// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// Holds the arbiter FSM state encoding, requester index encoding and the
// default address/data widths used by dmem_arbiter and dmem_arb_rr.
package dmem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;

  // Requester index: bit position in the req/grant vectors.
  localparam int REQ_CORE   = 0;
  localparam int REQ_LOADER = 1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_rr.sv
// Purpose: two-way round-robin tie-break, one-hot grant.
// Latency: purely combinational.
// Backpressure: none; a lone request always wins, a tie goes to the requester not granted last.
// Ports: req_i   - request vector (bit0 core, bit1 loader)
//        last_gnt_i - index of the most recently granted requester
//        gnt_o   - one-hot grant (all zero when no request)
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o[REQ_CORE]   = last_gnt_i;
      gnt_o[REQ_LOADER] = ~last_gnt_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose: arbitrates core LSU (m0) and loader/debug (m1) onto one single-port data RAM, with lock for RMW.
// Latency: grant and RAM strobe combinational in the request cycle; read data returns one cycle after grant.
// Backpressure: requester holds req/payload until gnt; a locked owner blocks the other requester.
// Ports: clk/rst (sync, active-high); mN_req/we/lock/addr/wdata/be in, mN_gnt/rvalid/rdata out;
//        mem_en/we/addr/wdata/be out to the RAM, mem_rdata in (valid the cycle after a read strobe).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic                    m0_lock,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic                    m1_lock,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  arb_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic [1:0] req;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;

  assign req = {m1_req, m0_req};

  dmem_arb_rr u_rr (
    .req_i      (req),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (rr_gnt)
  );

  // Next-state and grant. A locked owner dropping req, or issuing an
  // unlocked access, hands the RAM back to round-robin arbitration.
  always_comb begin
    state_d = state_q;
    gnt     = 2'b00;
    case (state_q)
      ARB: begin
        gnt = rr_gnt;
        if (rr_gnt[REQ_CORE] && m0_lock) begin
          state_d = LOCK0;
        end else if (rr_gnt[REQ_LOADER] && m1_lock) begin
          state_d = LOCK1;
        end
      end
      LOCK0: begin
        gnt[REQ_CORE] = m0_req;
        if (!m0_req || !m0_lock) begin
          state_d = ARB;
        end
      end
      LOCK1: begin
        gnt[REQ_LOADER] = m1_req;
        if (!m1_req || !m1_lock) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    // Grants are combinational, so reset has to mask them directly.
    if (rst) begin
      gnt = 2'b00;
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt[REQ_LOADER]) begin
      last_gnt_d = 1'b1;
    end else if (gnt[REQ_CORE]) begin
      last_gnt_d = 1'b0;
    end
    rvalid_d[REQ_CORE]   = gnt[REQ_CORE] & ~m0_we;
    rvalid_d[REQ_LOADER] = gnt[REQ_LOADER] & ~m1_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      last_gnt_q <= 1'b0;
      rvalid_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign m0_gnt = gnt[REQ_CORE];
  assign m1_gnt = gnt[REQ_LOADER];

  // A read in flight when reset arrives is dropped: the pending flag is
  // masked during reset and cleared by it.
  assign m0_rvalid = rvalid_q[REQ_CORE] & ~rst;
  assign m1_rvalid = rvalid_q[REQ_LOADER] & ~rst;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  // Payload mux; only meaningful while mem_en is high.
  assign mem_en    = |gnt;
  assign mem_we    = gnt[REQ_LOADER] ? m1_we : (gnt[REQ_CORE] ? m0_we : 1'b0);
  assign mem_addr  = gnt[REQ_LOADER] ? m1_addr  : m0_addr;
  assign mem_wdata = gnt[REQ_LOADER] ? m1_wdata : m0_wdata;
  assign mem_be    = gnt[REQ_LOADER] ? m1_be    : m0_be;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: self-checking bench for dmem_arbiter with a behavioural single-port RAM.
// Latency: stimulus drives #1 after posedge; grants and read responses are sampled on negedge.
// Backpressure: directed sequences hold req/payload until the expected grant.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [BW-1:0] m0_be;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_we, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [BW-1:0] m1_be;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  logic [DW-1:0] ram [0:(1<<AW)-1];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Single-port RAM: byte-enabled write, registered read.
  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge clk) begin
    if (m0_rvalid) begin
      if (q0.size() == 0) chk("m0_rvalid unexpected", 64'(m0_rvalid), 64'd0);
      else chk("m0_rdata", 64'(m0_rdata), 64'(q0.pop_front()));
    end else begin
      chk("m0_rdata idle zero", 64'(m0_rdata), 64'd0);
    end
    if (m1_rvalid) begin
      if (q1.size() == 0) chk("m1_rvalid unexpected", 64'(m1_rvalid), 64'd0);
      else chk("m1_rdata", 64'(m1_rdata), 64'(q1.pop_front()));
    end else begin
      chk("m1_rdata idle zero", 64'(m1_rdata), 64'd0);
    end
  end

  task automatic set_m0(input logic req, we, lock, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = a; m0_wdata = d; m0_be = be;
  endtask

  task automatic set_m1(input logic req, we, lock, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = a; m1_wdata = d; m1_be = be;
  endtask

  task automatic expect_gnt(input logic e0, input logic e1, input string name);
    @(negedge clk);
    chk({name, " m0_gnt"}, 64'(m0_gnt), 64'(e0));
    chk({name, " m1_gnt"}, 64'(m1_gnt), 64'(e1));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    set_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    repeat (2) next_cycle();

    // Reset state with both requesters active: nothing may reach the RAM.
    set_m0(1'b1, 1'b0, 1'b0, 10'h004, '0, 4'hF);
    set_m1(1'b1, 1'b0, 1'b0, 10'h005, '0, 4'hF);
    expect_gnt(1'b0, 1'b0, "reset");
    chk("reset mem_en", 64'(mem_en), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    next_cycle();
    rst = 1'b0;
    idle_all();
    next_cycle();

    // Write then read back the same word from m0.
    set_m0(1'b1, 1'b1, 1'b0, 10'h004, 32'hFFFFF63C, 4'hF);
    expect_gnt(1'b1, 1'b0, "m0 write");
    chk("m0 write mem_en", 64'(mem_en), 64'd1);
    chk("m0 write mem_we", 64'(mem_we), 64'd1);
    chk("m0 write mem_addr", 64'(mem_addr), 64'h004);
    chk("m0 write mem_wdata", 64'(mem_wdata), 64'hFFFFF63C);
    next_cycle();
    set_m0(1'b1, 1'b0, 1'b0, 10'h004, '0, 4'hF);
    expect_gnt(1'b1, 1'b0, "m0 read");
    chk("m0 read mem_we", 64'(mem_we), 64'd0);
    q0.push_back(32'hFFFFF63C);
    next_cycle();

    // Preload two more words via each port.
    idle_all();
    set_m1(1'b1, 1'b1, 1'b0, 10'h005, 32'h5A5A1234, 4'hF);
    expect_gnt(1'b0, 1'b1, "m1 write");
    chk("m1 write mem_addr", 64'(mem_addr), 64'h005);
    next_cycle();
    idle_all();
    set_m0(1'b1, 1'b1, 1'b0, 10'h010, 32'hCAFEF00D, 4'hF);
    expect_gnt(1'b1, 1'b0, "m0 write 010");
    next_cycle();
    idle_all();

    // Fresh reset so the round-robin pointer starts at 0.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    // Both read every cycle: m1, m0, m1, m0, m1, m0.
    set_m0(1'b1, 1'b0, 1'b0, 10'h004, '0, 4'hF);
    set_m1(1'b1, 1'b0, 1'b0, 10'h005, '0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        expect_gnt(1'b0, 1'b1, "tie alt");
        q1.push_back(32'h5A5A1234);
      end else begin
        expect_gnt(1'b1, 1'b0, "tie alt");
        q0.push_back(32'hFFFFF63C);
      end
      next_cycle();
    end
    idle_all();
    next_cycle();

    // m1 locked read-modify-write while m0 keeps requesting.
    set_m0(1'b1, 1'b0, 1'b0, 10'h004, '0, 4'hF);
    set_m1(1'b1, 1'b0, 1'b1, 10'h010, '0, 4'hF);
    expect_gnt(1'b0, 1'b1, "lock1 read");
    q1.push_back(32'hCAFEF00D);
    next_cycle();
    set_m1(1'b1, 1'b1, 1'b0, 10'h010, 32'h0BADBEEF, 4'hF);
    expect_gnt(1'b0, 1'b1, "lock1 write");
    next_cycle();
    set_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
    expect_gnt(1'b1, 1'b0, "after unlock");
    q0.push_back(32'hFFFFF63C);
    next_cycle();
    set_m0(1'b1, 1'b0, 1'b0, 10'h010, '0, 4'hF);
    expect_gnt(1'b1, 1'b0, "read rmw result");
    q0.push_back(32'h0BADBEEF);
    next_cycle();
    idle_all();

    // Back-to-back writes with partial byte enable, then read-after-write.
    set_m0(1'b1, 1'b1, 1'b0, 10'h020, 32'h11223344, 4'hF);
    expect_gnt(1'b1, 1'b0, "be full write");
    next_cycle();
    set_m0(1'b1, 1'b1, 1'b0, 10'h020, 32'h0000AA00, 4'h2);
    expect_gnt(1'b1, 1'b0, "be partial write");
    chk("be partial mem_be", 64'(mem_be), 64'h2);
    next_cycle();
    set_m0(1'b1, 1'b0, 1'b0, 10'h020, '0, 4'hF);
    expect_gnt(1'b1, 1'b0, "be read");
    q0.push_back(32'h1122AA44);
    next_cycle();
    idle_all();
    next_cycle();

    // Reset in LOCK0 with a read in flight drops it and releases the lock.
    set_m0(1'b1, 1'b0, 1'b1, 10'h004, '0, 4'hF);
    expect_gnt(1'b1, 1'b0, "lock0 enter");
    q0.push_back(32'hFFFFF63C);
    next_cycle();
    set_m1(1'b1, 1'b0, 1'b0, 10'h005, '0, 4'hF);
    expect_gnt(1'b1, 1'b0, "lock0 hold");
    next_cycle();
    rst = 1'b1;
    expect_gnt(1'b0, 1'b0, "reset in lock");
    chk("reset in lock m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("reset in lock mem_en", 64'(mem_en), 64'd0);
    next_cycle();
    rst = 1'b0;
    set_m0(1'b1, 1'b0, 1'b0, 10'h004, '0, 4'hF);
    expect_gnt(1'b0, 1'b1, "post reset tie");
    chk("post reset m0_rvalid", 64'(m0_rvalid), 64'd0);
    q1.push_back(32'h5A5A1234);
    next_cycle();
    idle_all();
    repeat (3) next_cycle();

    chk("m0 responses outstanding", 64'(q0.size()), 64'd0);
    chk("m1 responses outstanding", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
